// File: rtl/adder_accum_seq_if.sv
// Handshake and adder-return bundle for adder_accum_seq.
// The slave modport is the sequencer's view; master is the environment's view (producer, consumer, adder).
interface adder_accum_seq_if #(
   parameter int WIDTH = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_sub;
   logic             clear;
   logic [WIDTH-1:0] add_x;
   logic [WIDTH-1:0] add_y;
   logic             add_cin;
   logic [WIDTH-1:0] add_s;
   logic             add_cout;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_ovf;

   modport master (
      output in_valid, in_data, in_sub, clear, add_s, add_cout, out_ready,
      input  in_ready, add_x, add_y, add_cin, out_valid, out_data, out_ovf
   );

   modport slave (
      input  in_valid, in_data, in_sub, clear, add_s, add_cout, out_ready,
      output in_ready, add_x, add_y, add_cin, out_valid, out_data, out_ovf
   );
endinterface

// File: rtl/adder_accum_seq.sv
// Burst accumulator around an external combinational adder: COUNT operands per burst,
// result and sticky overflow/borrow flag presented on a valid/ready output.
module adder_accum_seq #(
   parameter int WIDTH = 5,
   parameter int COUNT = 4
) (
   input  logic                clk,
   input  logic                rst,
   adder_accum_seq_if.slave    bus
);
   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

   localparam logic [3:0] LP_COUNT = 4'(COUNT);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_acc;
   logic [3:0]       r_cnt;
   logic             r_ovf;

   logic w_rdy;
   logic w_done;
   logic w_hs;
   logic w_accept;
   logic w_last;
   logic w_ovf_term;
   logic w_release;

   // in_ready depends on state alone, so out_ready never reaches it combinationally
   assign w_rdy      = (r_state != S_DONE);
   assign w_done     = (r_state == S_DONE);
   assign w_hs       = bus.in_valid & w_rdy;
   assign w_accept   = w_hs & ~bus.clear;
   assign w_last     = ((r_cnt + 4'd1) == LP_COUNT);
   assign w_ovf_term = bus.in_sub ? ~bus.add_cout : bus.add_cout;
   assign w_release  = w_done & bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_ACCUM: begin
            if (bus.clear) begin
               w_state_nxt = S_IDLE;
            end else if (w_accept) begin
               w_state_nxt = w_last ? S_DONE : S_ACCUM;
            end
         end
         S_DONE: begin
            if (w_release) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = w_rdy;
      bus.out_valid = w_done;
      bus.out_data  = w_done ? r_acc : '0;
      bus.out_ovf   = w_done & r_ovf;
      bus.add_x     = r_acc;
      bus.add_y     = '0;
      bus.add_cin   = 1'b0;
      // Subtraction as acc + ~in_data + 1; the adder output is only captured when not cleared
      if (w_hs) begin
         bus.add_y   = bus.in_sub ? ~bus.in_data : bus.in_data;
         bus.add_cin = bus.in_sub;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (w_done) begin
         if (w_release) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
         end
      end else if (bus.clear) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (w_accept) begin
         r_acc <= bus.add_s;
         r_cnt <= r_cnt + 4'd1;
         r_ovf <= r_ovf | w_ovf_term;
      end
   end
endmodule
